tick_period_monitor: RTL and testbench
======================================

// Module: tick_period_monitor
// PURPOSE
//  Receive-side companion to the free-running tick generators. Watches a tick
//  stream and recovers the generator's programmed max_cnt (period - 1).
//  Declares lock after LOCK_COUNT identical consecutive periods.
//  Flags period changes while locked, and flags a timeout when ticks stop.
//  Sits downstream of a tick source; feeds status logic / rate checkers.
// PARAMETERS
//  WIDTH       8  width of period counter and period_out; max measurable period 2^WIDTH
//  LOCK_COUNT  4  consecutive equal periods required for lock (>=1)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      reset, asynchronous, active-high
//  enable       in   1      synchronous enable; low = clear to reset state
//  tick_in      in   1      tick stream, sampled every rising edge (may be held high)
//  period_out   out  WIDTH  last measured period minus 1 (== generator max_cnt)
//  period_valid out  1      1-cycle pulse: period_out updated this cycle
//  locked       out  1      LOCK_COUNT consecutive equal periods observed
//  mismatch     out  1      1-cycle pulse: period changed while locked
//  timeout_err  out  1      1-cycle pulse: no tick within 2^WIDTH cycles
// BEHAVIOUR
//  - reset (async) or enable=0 (sync, evaluated each edge):
//    state=IDLE; cnt, ref_period, match_cnt, period_out = 0.
//    period_valid, locked, mismatch, timeout_err = 0.
//  - All outputs are registered.
//  - Counter: at an edge with tick_in=1, cnt<=0. Otherwise cnt<=cnt+1.
//    For ticks at edges t and t+P, cnt==P-1 at edge t+P.
//  - States:
//    IDLE: waits for the first tick. On tick -> MEASURE; no period reported.
//    MEASURE: on tick, measured value = cnt.
//      period_out<=cnt; period_valid<=1 (visible the cycle after the tick edge).
//      If match_cnt==0 or cnt!=ref_period: ref_period<=cnt, match_cnt<=1.
//      Otherwise match_cnt<=match_cnt+1.
//      When the new match_cnt==LOCK_COUNT: locked<=1, state->LOCKED.
//      This happens on the same edge as that period_valid.
//      With LOCK_COUNT=1, the first measured period locks.
//    LOCKED: on tick, period_out<=cnt and period_valid<=1.
//      If cnt!=ref_period: mismatch<=1, locked<=0, ref_period<=cnt,
//      match_cnt<=1, state->MEASURE.
//  - Timeout: in MEASURE or LOCKED, with cnt==2^WIDTH-1 and tick_in=0:
//    timeout_err<=1, locked<=0, match_cnt<=0, cnt<=0, state->IDLE.
//    period_out holds its last value.
//    Tick gap of 2^WIDTH cycles is legal: period_out=2^WIDTH-1, no timeout.
//    Gap of 2^WIDTH+1 cycles times out.
//    In IDLE, cnt is held at 0 and no timeout is raised.
//  - Simultaneous tick and cnt==max: the tick wins and is measured normally.
//  - Pulses (period_valid, mismatch, timeout_err) deassert the next cycle
//    unless re-triggered.
//  - Reset or enable drop mid-period: the partial period is discarded.
//    The first tick afterwards only re-arms (IDLE->MEASURE).
// TESTING
//  1. Ticks every 5 cycles, LOCK_COUNT=4 -> period_out=4 on each valid.
//     locked=1 with the 4th period_valid (5th tick). No mismatch.
//  2. tick_in held 1 continuously -> period_out=0 each cycle; locked after 4 valids.
//  3. Locked at period 5, then gap 8 -> period_out=7, mismatch pulse, locked=0.
//     Relock after 4 valids of 7 in total.
//  4. Locked, then ticks stop -> timeout_err pulse 256 cycles after last tick edge.
//     locked=0. Next tick gives no period_valid; the following tick reports.
//  5. Tick gap exactly 256 -> period_out=255, timeout_err never asserted.
//  6. Drive enable=0 mid-lock, and separately pulse reset mid-period.
//     -> All outputs 0 immediately (reset) or next edge (enable).
//     The first tick after release produces no period_valid.

Source files
------------

// File: rtl/tick_period_monitor.sv
// Recovers a tick generator's programmed max_cnt from the spacing of its ticks,
// declares lock after LOCK_COUNT equal periods, and flags changes and dropouts.
module tick_period_monitor #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick_in,
    output logic [WIDTH-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout_err
);

    // One spare count of headroom so a post-mismatch relock with LOCK_COUNT=1 cannot wrap.
    localparam int MW = $clog2(LOCK_COUNT + 2);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [MW-1:0]    M_ZERO   = {MW{1'b0}};
    localparam logic [MW-1:0]    M_ONE    = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0]    M_LOCK   = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] ref_r, ref_s;
    logic [MW-1:0]    match_r, match_s;
    logic [MW-1:0]    match_inc_s;
    logic [WIDTH-1:0] period_s;
    logic             valid_s, locked_s, mismatch_s, timeout_s;

    // Next-state and next-output logic for the whole monitor.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        ref_s       = ref_r;
        match_s     = match_r;
        period_s    = period_out;
        valid_s     = 1'b0;
        locked_s    = locked;
        mismatch_s  = 1'b0;
        timeout_s   = 1'b0;
        match_inc_s = ((match_r == M_ZERO) || (cnt_r != ref_r)) ? M_ONE : (match_r + M_ONE);

        if (!enable) begin
            state_s  = IDLE;
            cnt_s    = CNT_ZERO;
            ref_s    = CNT_ZERO;
            match_s  = M_ZERO;
            period_s = CNT_ZERO;
            locked_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_s = CNT_ZERO;
                    if (tick_in) begin
                        state_s = MEASURE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                MEASURE: begin
                    if (tick_in) begin
                        cnt_s    = CNT_ZERO;
                        period_s = cnt_r;
                        valid_s  = 1'b1;
                        match_s  = match_inc_s;
                        if (match_inc_s == M_ONE) begin
                            ref_s = cnt_r;
                        end else begin
                            ref_s = ref_r;
                        end
                        if (match_inc_s >= M_LOCK) begin
                            locked_s = 1'b1;
                            state_s  = LOCKED;
                        end else begin
                            state_s  = MEASURE;
                        end
                    end else if (cnt_r == CNT_MAX) begin
                        timeout_s = 1'b1;
                        locked_s  = 1'b0;
                        match_s   = M_ZERO;
                        cnt_s     = CNT_ZERO;
                        state_s   = IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                LOCKED: begin
                    if (tick_in) begin
                        cnt_s    = CNT_ZERO;
                        period_s = cnt_r;
                        valid_s  = 1'b1;
                        if (cnt_r != ref_r) begin
                            mismatch_s = 1'b1;
                            locked_s   = 1'b0;
                            ref_s      = cnt_r;
                            match_s    = M_ONE;
                            state_s    = MEASURE;
                        end else begin
                            state_s    = LOCKED;
                        end
                    end else if (cnt_r == CNT_MAX) begin
                        timeout_s = 1'b1;
                        locked_s  = 1'b0;
                        match_s   = M_ZERO;
                        cnt_s     = CNT_ZERO;
                        state_s   = IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s  = IDLE;
                    cnt_s    = CNT_ZERO;
                    match_s  = M_ZERO;
                    locked_s = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r        <= CNT_ZERO;
            ref_r        <= CNT_ZERO;
            match_r      <= M_ZERO;
            period_out   <= CNT_ZERO;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            mismatch     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            cnt_r        <= cnt_s;
            ref_r        <= ref_s;
            match_r      <= match_s;
            period_out   <= period_s;
            period_valid <= valid_s;
            locked       <= locked_s;
            mismatch     <= mismatch_s;
            timeout_err  <= timeout_s;
        end
    end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Self-checking bench: directed scenarios plus random tick streams, compared
// against an event-time reference model of the period monitor.
module tb_tick_period_monitor;

    localparam int WIDTH = 8;
    localparam int LOCK  = 4;
    localparam int SPAN  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             tick_in;
    logic [WIDTH-1:0] period_out;
    logic             period_valid, locked, mismatch, timeout_err;

    tick_period_monitor #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .tick_in      (tick_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .mismatch     (mismatch),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model: works on absolute tick times and runs of equal periods.
    bit               m_armed;
    int               m_last;
    int               m_run_val;
    int               m_run_len;
    logic [WIDTH-1:0] m_period;
    logic             m_valid, m_locked, m_mis, m_to;

    wire [WIDTH+3:0] obs  = {period_out, period_valid, locked, mismatch, timeout_err};
    wire [WIDTH+3:0] expv = {m_period, m_valid, m_locked, m_mis, m_to};

    task automatic model_clear();
        m_armed   = 1'b0;
        m_run_len = 0;
        m_run_val = 0;
        m_period  = '0;
        m_valid   = 1'b0;
        m_locked  = 1'b0;
        m_mis     = 1'b0;
        m_to      = 1'b0;
    endtask

    task automatic model_edge(input logic t, input logic e);
        int gap;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_to    = 1'b0;
        if (!e) begin
            model_clear();
        end else if (!m_armed) begin
            if (t) begin
                m_armed = 1'b1;
                m_last  = cyc;
            end
        end else begin
            gap = cyc - m_last;
            if (t) begin
                m_period = WIDTH'(gap - 1);
                m_valid  = 1'b1;
                m_last   = cyc;
                if (m_run_len > 0 && (gap - 1) == m_run_val) begin
                    m_run_len++;
                end else begin
                    if (m_locked) m_mis = 1'b1;
                    m_locked  = 1'b0;
                    m_run_val = gap - 1;
                    m_run_len = 1;
                end
                if (m_run_len >= LOCK) m_locked = 1'b1;
            end else if (gap == SPAN) begin
                m_to      = 1'b1;
                m_armed   = 1'b0;
                m_locked  = 1'b0;
                m_run_len = 0;
            end
        end
    endtask

    // Apply inputs, take one clock edge, advance the model; ends 1 time unit after the edge.
    task automatic cycle(input logic t, input logic e);
        tick_in = t;
        enable  = e;
        @(posedge clk);
        cyc++;
        model_edge(t, e);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; tick_in = 1'b0;
        model_clear();
        #12;
        vectors++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs, expv);
        end
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 1'b1);
    endtask

    task automatic test_period5();
        for (int i = 0; i < 36; i++) begin
            cycle((i % 5) == 0, 1'b1);
            vectors++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL period5 cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
        end
        vectors++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL period5_locked got=%b exp=1", locked);
        end
    endtask

    task automatic test_held_high();
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1);
            vectors++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL held_high cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_mismatch();
        cycle(1'b0, 1'b0);
        for (int i = 0; i <= 25; i++) cycle((i % 5) == 0, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            cycle((i % 8) == 0, 1'b1);
            vectors++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL mismatch cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_timeout();
        int to_at;
        cycle(1'b0, 1'b0);
        for (int i = 0; i <= 25; i++) cycle((i % 5) == 0, 1'b1);
        to_at = -1;
        for (int i = 1; i <= 300; i++) begin
            cycle(1'b0, 1'b1);
            if (timeout_err === 1'b1) to_at = i;
            vectors++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
        end
        vectors++;
        if (to_at !== SPAN) begin
            errors++;
            $display("FAIL timeout_latency got=%0d exp=%0d", to_at, SPAN);
        end
        for (int i = 0; i < 22; i++) begin
            cycle((i % 10) == 0, 1'b1);
            vectors++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL timeout_rearm cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_gap256();
        cycle(1'b0, 1'b0);
        for (int i = 0; i <= 3 * SPAN + 2; i++) begin
            cycle((i % SPAN) == 0, 1'b1);
            vectors++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL gap256 cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_enable_drop();
        for (int i = 0; i <= 27; i++) cycle((i % 5) == 0, 1'b1);
        cycle(1'b0, 1'b0);
        vectors++;
        if (obs !== {WIDTH+4{1'b0}}) begin
            errors++;
            $display("FAIL enable_clear got=%h exp=0", obs);
        end
        for (int i = 0; i < 14; i++) begin
            cycle((i % 6) == 0, 1'b1);
            vectors++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL enable_release cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i <= 23; i++) cycle((i % 4) == 0, 1'b1);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        vectors++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", obs, expv);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cycle((i % 3) == 1, 1'b1);
            vectors++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        int period, reps, k;
        logic e;
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(0, 19) == 0) period = $urandom_range(SPAN - 2, SPAN + 2);
            else                            period = $urandom_range(1, 12);
            reps = $urandom_range(1, 6);
            for (int r = 0; r < reps; r++) begin
                for (k = 0; k < period; k++) begin
                    e = ($urandom_range(0, 199) != 0);
                    cycle((k == period - 1), e);
                    vectors++;
                    if (obs !== expv) begin
                        errors++;
                        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_period5();
        test_held_high();
        test_mismatch();
        test_timeout();
        test_gap256();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
